// File: rtl/signature_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : signature_accumulator
//  Description : Self-checking signature generator. Sweeps a stimulus counter
//                from 0 to all-ones and folds a scrambled mix of the observed
//                channels into an ACC_W-bit signature. Compaction is either
//                rotate-add (mode 0) or LFSR/MISR (mode 1).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   rising-edge clock
//    reset            in   asynchronous clear, active low
//    sync_reset       in   synchronous clear, active high (beats start)
//    start            in   begin a sweep; honoured only in IDLE or DONE
//    mode             in   0 = rotate-add, 1 = LFSR; latched on accepted start
//    seed             in   scrambler seed; latched on accepted start
//    ch_data          in   NUM_CH packed channels, channel k at [k*DATA_W +: DATA_W]
//    ch_enable        in   per-channel mask, used live every cycle
//    stimulus         out  counter value presented to the DUT
//    signature        out  accumulated signature
//    busy             out  high while sweeping
//    done             out  one-cycle pulse on the edge that enters DONE
//    signature_valid  out  high while in DONE
//  ACC_W must be at least DATA_W+2 so the rotate-add field layout is legal.
// ============================================================================
module signature_accumulator #(
    parameter int              DATA_W = 8,
    parameter int              ACC_W  = 16,
    parameter int              CNT_W  = 8,
    parameter int              NUM_CH = 4,
    parameter logic [ACC_W-1:0] POLY  = 16'h8016
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sync_reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic [DATA_W-1:0]        seed,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_enable,
    output logic [CNT_W-1:0]         stimulus,
    output logic [ACC_W-1:0]         signature,
    output logic                     busy,
    output logic                     done,
    output logic                     signature_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                load;
    logic                step;
    logic                finish;
    logic                mode_l;
    logic [DATA_W-1:0]   seed_l;
    logic [CNT_W-1:0]    count_inc;
    logic [DATA_W-1:0]   stim_ext;
    logic [DATA_W-1:0]   ch_fold;
    logic [DATA_W-1:0]   scr;
    logic [DATA_W-1:0]   add_sum;
    logic                lfsr_fb;
    logic [ACC_W-1:0]    sig_next;

    assign count_inc = stimulus + 1'b1;

    // Counter bits feeding the scrambler: truncate a wide counter, zero-extend
    // a narrow one.
    generate
        if (CNT_W >= DATA_W) begin : g_stim_trunc
            assign stim_ext = stimulus[DATA_W-1:0];
        end else begin : g_stim_zext
            assign stim_ext = {{(DATA_W-CNT_W){1'b0}}, stimulus};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Compaction datapath
    // ------------------------------------------------------------------
    always_comb begin
        ch_fold = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_enable[k]) begin
                ch_fold = ch_fold ^ ch_data[k*DATA_W +: DATA_W];
            end
        end
        scr     = seed_l ^ stim_ext ^ ch_fold;
        // Low DATA_W bits plus scrambled word, carry discarded.
        add_sum = signature[DATA_W-1:0] + scr;
        lfsr_fb = ^(signature & POLY);
        if (mode_l) begin
            sig_next = {signature[ACC_W-2:0], lfsr_fb} ^ {{(ACC_W-DATA_W){1'b0}}, scr};
        end else begin
            // Sum lands one bit up; the old MSB wraps into bit 0.
            sig_next = {signature[ACC_W-2:DATA_W], add_sum, signature[ACC_W-1]};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else if (sync_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stimulus != CNT_MAX) begin
                    step = 1'b1;
                    if (count_inc == CNT_MAX) begin
                        finish     = 1'b1;
                        state_next = ST_DONE;
                    end
                end else begin
                    // Unreachable in normal operation: the sweep always leaves
                    // RUN as the counter reaches all-ones.
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy            = (state == ST_RUN);
    assign signature_valid = (state == ST_DONE);

    // ------------------------------------------------------------------
    // Counter, signature, latched configuration and done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stimulus  <= '0;
            signature <= '0;
            mode_l    <= 1'b0;
            seed_l    <= '0;
            done      <= 1'b0;
        end else if (sync_reset) begin
            stimulus  <= '0;
            signature <= '0;
            mode_l    <= 1'b0;
            seed_l    <= '0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                stimulus  <= '0;
                signature <= '0;
                seed_l    <= seed;
                mode_l    <= mode;
            end else if (step) begin
                stimulus  <= count_inc;
                signature <= sig_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_signature_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_signature_accumulator
//  Description : Scoreboard bench for signature_accumulator. A small instance
//                (4/8/2) is traced cycle by cycle against hand-computed
//                vectors; a default-parameter instance is checked at each done
//                pulse against a golden sweep model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_signature_accumulator;

    localparam logic [15:0] POLY_TB = 16'h8016;

    logic        clk;
    logic        reset;
    logic        sync_reset;

    // default-parameter instance
    logic        start;
    logic        mode;
    logic [7:0]  seed;
    logic [31:0] ch_data;
    logic [3:0]  ch_enable;
    logic [7:0]  stimulus;
    logic [15:0] signature;
    logic        busy;
    logic        done;
    logic        signature_valid;

    // small instance
    logic        s_start;
    logic        s_mode;
    logic [3:0]  s_seed;
    logic [15:0] s_ch_data;
    logic [3:0]  s_ch_enable;
    logic [1:0]  s_stim;
    logic [7:0]  s_sig;
    logic        s_busy;
    logic        s_done;
    logic        s_valid;

    int n_cmp = 0;
    int n_err = 0;
    int done_count = 0;
    int cyc = 0;

    logic [12:0] s_q[$];   // {busy, done, valid, stim, sig}
    logic [15:0] d_q[$];   // expected final signature per sweep

    signature_accumulator u_dut (
        .clk(clk), .reset(reset), .sync_reset(sync_reset), .start(start),
        .mode(mode), .seed(seed), .ch_data(ch_data), .ch_enable(ch_enable),
        .stimulus(stimulus), .signature(signature), .busy(busy), .done(done),
        .signature_valid(signature_valid)
    );

    signature_accumulator #(
        .DATA_W(4), .ACC_W(8), .CNT_W(2), .NUM_CH(4), .POLY(8'h8E)
    ) u_small (
        .clk(clk), .reset(reset), .sync_reset(sync_reset), .start(s_start),
        .mode(s_mode), .seed(s_seed), .ch_data(s_ch_data), .ch_enable(s_ch_enable),
        .stimulus(s_stim), .signature(s_sig), .busy(s_busy), .done(s_done),
        .signature_valid(s_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Golden sweep for the default-parameter configuration.
    function automatic logic [15:0] golden(input logic m, input logic [7:0] sd,
                                           input logic [31:0] chd, input logic [3:0] che);
        logic [15:0] acc;
        logic [7:0]  fold;
        logic [7:0]  scr;
        logic [7:0]  lo;
        logic        fb;
        acc  = 16'h0000;
        fold = 8'h00;
        for (int k = 0; k < 4; k++)
            if (che[k]) fold = fold ^ chd[8*k +: 8];
        for (int c = 0; c < 255; c++) begin
            scr = sd ^ 8'(c) ^ fold;
            if (!m) begin
                lo  = acc[7:0] + scr;
                acc = {acc[14:8], lo, acc[15]};
            end else begin
                fb = 1'b0;
                for (int i = 0; i < 16; i++)
                    if (POLY_TB[i]) fb = fb ^ acc[i];
                acc = {acc[14:0], fb} ^ {8'h00, scr};
            end
        end
        return acc;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (s_busy || s_done) begin
            if (s_q.size() == 0) fail_now("small_unexpected_output");
            else check("small_trace", {s_busy, s_done, s_valid, s_stim, s_sig}, s_q.pop_front());
        end
    end

    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            done_count++;
            if (prev_done) fail_now("done_wider_than_one_cycle");
            if (d_q.size() == 0) fail_now("unexpected_done");
            else check("final_signature", {stimulus, busy, signature_valid, signature},
                       {8'hFF, 1'b0, 1'b1, d_q.pop_front()});
        end
        prev_done = done;
    end

    // ---------------- helpers ----------------
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_s_start();
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (!done) fail_now({tag, "_timeout"});
    endtask

    task automatic wait_s_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_done && n < budget);
        if (!s_done) fail_now("small_done_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c1;
        int c2;
        logic [15:0] g;

        reset = 1'b0; sync_reset = 1'b0;
        start = 1'b0; mode = 1'b0; seed = 8'h00; ch_data = 32'h0; ch_enable = 4'h0;
        s_start = 1'b0; s_mode = 1'b0; s_seed = 4'h0; s_ch_data = 16'h0; s_ch_enable = 4'h0;
        #12 reset = 1'b1;

        // reset state
        @(negedge clk);
        check("reset_default", {stimulus, signature, busy, done, signature_valid}, 0);
        check("reset_small", {s_stim, s_sig, s_busy, s_done, s_valid}, 0);

        // small instance, channels off: 00,00,02,08
        s_q.push_back({1'b1, 1'b0, 1'b0, 2'd0, 8'h00});
        s_q.push_back({1'b1, 1'b0, 1'b0, 2'd1, 8'h00});
        s_q.push_back({1'b1, 1'b0, 1'b0, 2'd2, 8'h02});
        s_q.push_back({1'b0, 1'b1, 1'b1, 2'd3, 8'h08});
        pulse_s_start();
        wait_s_done(20);
        @(negedge clk);
        check("small_done_state", {s_valid, s_done, s_busy, s_stim}, {1'b1, 1'b0, 1'b0, 2'd3});

        // small instance, ch0 = F (others masked): scr F,E,D -> 1E,38,6A
        s_ch_enable = 4'b0001;
        s_ch_data   = 16'h7A3F;
        s_q.push_back({1'b1, 1'b0, 1'b0, 2'd0, 8'h00});
        s_q.push_back({1'b1, 1'b0, 1'b0, 2'd1, 8'h1E});
        s_q.push_back({1'b1, 1'b0, 1'b0, 2'd2, 8'h38});
        s_q.push_back({1'b0, 1'b1, 1'b1, 2'd3, 8'h6A});
        pulse_s_start();
        wait_s_done(20);
        @(negedge clk);
        check("small_queue_drained", s_q.size(), 0);

        // sync_reset at stimulus 0x40 with start high
        pulse_start();
        begin
            int n;
            n = 0;
            while (stimulus != 8'h40 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        check("reach_stim_40", stimulus, 8'h40);
        sync_reset = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        check("sync_reset_clears", {stimulus, signature, busy, done, signature_valid}, 0);
        sync_reset = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        check("sync_reset_stays_idle", {busy, signature_valid, stimulus}, 0);

        // asynchronous reset pulse mid-RUN
        seed = 8'h5A;
        pulse_start();
        repeat (20) @(negedge clk);
        check("run_before_async", {busy, (signature != 16'h0)}, 2'b11);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check("async_reset_clears", {stimulus, signature, busy, done, signature_valid}, 0);
        #1 reset = 1'b1;
        @(negedge clk);
        check("async_reset_idle", {busy, stimulus}, 0);

        // MISR, seed 0, channels off, two back-to-back sweeps
        mode = 1'b1; seed = 8'h00; ch_enable = 4'h0; ch_data = 32'hDEADBEEF;
        g = golden(1'b1, 8'h00, 32'h0, 4'h0);
        d_q.push_back(g);
        pulse_start();
        wait_done(300, "misr_sweep1");
        d_q.push_back(g);
        pulse_start();
        // mode/seed must be latched: disturb them mid-sweep
        repeat (10) @(posedge clk);
        #1 mode = 1'b0; seed = 8'hFF;
        wait_done(300, "misr_sweep2");
        check("misr_repeat_equal", signature, g);

        // MISR with seed and one live channel
        mode = 1'b1; seed = 8'h3C; ch_enable = 4'b0010; ch_data = 32'h11_22_96_44;
        d_q.push_back(golden(1'b1, 8'h3C, 32'h11_22_96_44, 4'b0010));
        pulse_start();
        wait_done(300, "misr_channel");

        // rotate-add with seed and two of four channels enabled
        mode = 1'b0; seed = 8'h5A; ch_enable = 4'b0101; ch_data = 32'h80_24_FF_11;
        d_q.push_back(golden(1'b0, 8'h5A, 32'h80_24_FF_11, 4'b0101));
        pulse_start();
        wait_done(300, "rotadd_channels");

        // start held high: no restart in RUN, restart on DONE
        mode = 1'b0; seed = 8'hC3; ch_enable = 4'b0001; ch_data = 32'h0000_0077;
        g = golden(1'b0, 8'hC3, 32'h0000_0077, 4'b0001);
        d_q.push_back(g);
        d_q.push_back(g);
        @(posedge clk); #1 start = 1'b1;
        wait_done(300, "held_sweep1");
        c1 = cyc;
        wait_done(300, "held_sweep2");
        c2 = cyc;
        start = 1'b0;
        check("held_start_period", c2 - c1, 256);
        @(negedge clk);
        check("held_parks_in_done", {signature_valid, busy, done}, 3'b100);

        repeat (3) @(negedge clk);
        check("done_pulse_count", done_count, 6);
        check("default_queue_drained", d_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
